pwm_multi_modulator: RTL and testbench
======================================

Name: pwm_multi_modulator

Overview:
Multi-channel PWM generator sharing one prescaler and one carrier counter across CHANNELS outputs. Supports edge-aligned (sawtooth) and center-aligned (triangle) carriers, a duty range that reaches a true 100%, per-channel output polarity, and glitch-free duty updates through shadow registers loaded at period boundaries. It drives motor, LED and audio outputs from the bus-side register block.

Parameters:
CHANNELS, 4, number of PWM outputs
RES_BITS, 8, carrier resolution; MAX = 2^RES_BITS - 1
DIV_W, 32, width of the prescaler divisor input

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-low reset (0 = reset)
EN  input  1  run enable
MODE  input  1  0 = edge-aligned, 1 = center-aligned; sampled only at period boundary
DIV  input  DIV_W  carrier tick period in CLK cycles; 0 is treated as 1
DUTY  input  CHANNELS*(RES_BITS+1)  packed duty values, channel 0 in LSBs; range 0..2^RES_BITS
LOAD_EN  input  1  permits the shadow load at the next boundary
POL  input  CHANNELS  per-channel polarity; 1 inverts the output
MOUT  output  CHANNELS  PWM outputs, registered
PERIOD_END  output  1  one-cycle pulse at each period boundary
CNT  output  RES_BITS  current carrier count, for debug and sync

Behaviour:
- Reset (RST=0, asynchronous): prescaler counter, CNT, direction (up), all duty shadows, and the mode shadow go to 0. MOUT=0 and PERIOD_END=0. No CLK edge is required.
- Prescaler: counter runs 0..DIV-1. tick is asserted when counter >= DIV-1; on tick the counter returns to 0. The >= comparison makes a DIV decrease wrap immediately. With DIV=0 or 1, tick fires every cycle.
- Edge mode carrier: on tick, CNT increments and wraps MAX->0. Period = 2^RES_BITS ticks.
- Center mode carrier: on tick, CNT counts up 0->MAX, then down MAX-1->1, then 0. Direction flips on reaching MAX and on reaching 0. Period = 2*MAX ticks.
- Boundary: the tick on which CNT becomes 0. In the same edge:
  - the mode shadow loads MODE;
  - if LOAD_EN=1, every duty shadow loads its DUTY slice;
  - PERIOD_END goes high for exactly one CLK cycle.
- Outside boundaries, DUTY and MODE changes have no effect on the output.
- Compare: active[ch] = (CNT < shadow[ch]), using an unsigned (RES_BITS+1)-bit comparison.
  - duty 0 gives an output that is never active.
  - duty 2^RES_BITS gives an output that is always active, with no glitch at wrap.
- Output: MOUT[ch] is registered as active[ch] XOR POL[ch]. It lags CNT by one CLK cycle. POL takes effect on the next CLK edge and is not shadowed.
- EN=0:
  - prescaler, CNT and direction are held at 0/up;
  - MOUT = POL, registered;
  - shadows and mode shadow load DUTY, MODE and LOAD_EN-qualified values every cycle;
  - PERIOD_END = 0.
- EN rising: carrier starts at CNT=0 with the freshly loaded shadows. The first PERIOD_END occurs at the end of the first full period.
- Simultaneous events: tick and boundary in the same cycle is the normal case. Reset dominates everything.
- Mode change at a boundary: the new carrier starts from CNT=0, counting up.

Decomposition:
- Package pwm_pkg holds:
  - MODE_EDGE=1'b0 and MODE_CENTER=1'b1;
  - default RES_BITS and DIV_W;
  - a function extracting channel n's duty slice from the packed bus.
- Sub-module pwm_prescaler (CLK, RST, DIV -> TICK) holds the divisor counter and its >= wrap rule.
- The carrier counter, shadows and compare logic stay in the top level, with one generate loop over channels.

Test Plan:
Common setup for all scenarios: RES_BITS=4, CHANNELS=2, DIV=2, EN=1, LOAD_EN=1, POL=0.
- Edge mode, DUTY0=4: MOUT[0] is high 8 CLK and low 24 CLK per 32-CLK period. PERIOD_END pulses every 32 CLK.
- Duty limits, DUTY0=0 and DUTY1=16: MOUT[0] is constantly 0 and MOUT[1] constantly 1 over 3 periods, with no single-cycle glitch at the CNT wrap.
- Shadow update: DUTY0 changes 4->12 at CNT=6. The current period keeps 4 ticks high. After the next PERIOD_END it is 12 ticks high. With LOAD_EN=0 at the boundary, it stays at 4.
- Center mode, DUTY0=8: period is 30 ticks (60 CLK). MOUT[0] is high for 15 ticks, CNT 0..7 up and 7..1 down, and the high region is contiguous across the wrap.
- POL/EN: POL[1]=1 with DUTY1=4 gives MOUT[1] low 4 ticks and high 12 ticks. EN=0 mid-period gives CNT=0, MOUT=POL=2'b10 and PERIOD_END=0. Re-enabling restarts from CNT=0.
- Async reset: RST driven low between CLK edges mid-period clears MOUT=0, CNT=0 and PERIOD_END=0 immediately. After release with DIV=5, the first tick arrives 5 CLK later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: carrier mode encoding,
// default widths and the helper that unpacks one channel's duty value.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  localparam int DEF_RES_BITS = 8;
  localparam int DEF_DIV_W    = 32;

  // Widest packed duty bus the slice helper accepts.
  localparam int DUTY_BUS_MAX = 1024;

  function automatic logic [31:0] duty_slice(input logic [DUTY_BUS_MAX-1:0] bus,
                                             input int n, input int w);
    logic [DUTY_BUS_MAX-1:0] shifted;
    shifted = bus >> (n * w);
    return shifted[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Carrier tick generator: counts 0..DIV-1 and pulses TICK on the last count.
// DIV of 0 or 1 produces a tick on every enabled cycle.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  output logic             TICK
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  // A >= compare lets a shrinking divisor wrap at once instead of running to overflow.
  assign last = (DIV == '0) ? '0 : DIV - DIV_W'(1);
  assign TICK = EN && (count >= last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              count <= '0;
    else if (!EN || TICK)  count <= '0;
    else                   count <= count + DIV_W'(1);
  end

endmodule

// File: rtl/pwm_multi_modulator.sv
// Multi-channel PWM with a shared prescaler and carrier (sawtooth or triangle),
// shadowed duty/mode registers loaded at period boundaries, and per-channel polarity.
module pwm_multi_modulator
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RES_BITS = DEF_RES_BITS,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             EN,
  input  logic                             MODE,
  input  logic [DIV_W-1:0]                 DIV,
  input  logic [CHANNELS*(RES_BITS+1)-1:0] DUTY,
  input  logic                             LOAD_EN,
  input  logic [CHANNELS-1:0]              POL,
  output logic [CHANNELS-1:0]              MOUT,
  output logic                             PERIOD_END,
  output logic [RES_BITS-1:0]              CNT
);

  localparam int DW = RES_BITS + 1;
  localparam logic [RES_BITS-1:0] MAX = '1;

  logic                    tick;
  pwm_mode_e               mode_q;
  logic                    dir_down;
  logic                    dir_next;
  logic [RES_BITS-1:0]     cnt_q;
  logic [RES_BITS-1:0]     cnt_next;
  logic                    boundary;
  logic                    load_now;
  logic                    period_end_q;
  logic [DUTY_BUS_MAX-1:0] duty_wide;

  pwm_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .DIV  (DIV),
    .TICK (tick)
  );

  // Next carrier value; a boundary is any tick that lands the carrier on zero.
  always_comb begin
    cnt_next = cnt_q;
    dir_next = dir_down;
    if (tick) begin
      if (mode_q == MODE_CENTER) begin
        if (!dir_down) begin
          cnt_next = cnt_q + 1'b1;
          if (cnt_next == MAX) dir_next = 1'b1;
        end else begin
          cnt_next = cnt_q - 1'b1;
          if (cnt_next == '0) dir_next = 1'b0;
        end
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end
    boundary = tick && (cnt_next == '0);
    if (boundary) dir_next = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q        <= '0;
      dir_down     <= 1'b0;
      mode_q       <= MODE_EDGE;
      period_end_q <= 1'b0;
    end else if (!EN) begin
      cnt_q        <= '0;
      dir_down     <= 1'b0;
      mode_q       <= pwm_mode_e'(MODE);
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_next;
      dir_down     <= dir_next;
      period_end_q <= boundary;
      if (boundary) mode_q <= pwm_mode_e'(MODE);
    end
  end

  // While stopped the shadows track the inputs so a restart uses fresh values.
  assign load_now  = !EN || boundary;
  assign duty_wide = DUTY_BUS_MAX'(DUTY);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [DW-1:0] shadow;
    logic          active;
    logic          out_q;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                    shadow <= '0;
      else if (load_now && LOAD_EN) shadow <= DW'(duty_slice(duty_wide, ch, DW));
    end

    // The extra compare bit lets a full-scale duty stay active through the wrap.
    assign active = {1'b0, cnt_q} < shadow;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) out_q <= 1'b0;
      else      out_q <= EN ? (active ^ POL[ch]) : POL[ch];
    end

    assign MOUT[ch] = out_q;
  end

  assign PERIOD_END = period_end_q;
  assign CNT        = cnt_q;

endmodule

// File: tb/tb_pwm_multi_modulator.sv
// Directed bench for pwm_multi_modulator with RES_BITS=4, CHANNELS=2, DIV=2:
// duty shapes, limits, shadow timing, center mode, polarity, enable and reset.
module tb_pwm_multi_modulator;

  logic        clk;
  logic        rstN;
  logic        en;
  logic        mode;
  logic [31:0] div;
  logic [9:0]  duty;
  logic        loadEn;
  logic [1:0]  pol;
  logic [1:0]  mout;
  logic        periodEnd;
  logic [3:0]  cnt;

  int total = 0;
  int bad   = 0;

  int   hi0, hi1, peCnt, tog0, tog1, k;
  logic first0, prev0, prev1;

  pwm_multi_modulator #(
    .CHANNELS (2),
    .RES_BITS (4),
    .DIV_W    (32)
  ) dut (
    .CLK        (clk),
    .RST        (rstN),
    .EN         (en),
    .MODE       (mode),
    .DIV        (div),
    .DUTY       (duty),
    .LOAD_EN    (loadEn),
    .POL        (pol),
    .MOUT       (mout),
    .PERIOD_END (periodEnd),
    .CNT        (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] d1, input logic [4:0] d0);
    duty = {d1, d0};
  endtask

  // Samples n negedges and accumulates high counts, toggles and period pulses.
  task automatic measure(input int n);
    hi0 = 0; hi1 = 0; peCnt = 0; tog0 = 0; tog1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        first0 = mout[0];
      end else begin
        if (mout[0] != prev0) tog0++;
        if (mout[1] != prev1) tog1++;
      end
      prev0 = mout[0];
      prev1 = mout[1];
      if (mout[0])   hi0++;
      if (mout[1])   hi1++;
      if (periodEnd) peCnt++;
    end
  endtask

  task automatic syncPeriod(input string tag);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (periodEnd !== 1'b1 && w < 200);
    checkOutput(tag, 32'(periodEnd), 32'd1);
  endtask

  initial begin
    rstN = 1'b0; en = 1'b0; mode = 1'b0; div = 32'd2;
    loadEn = 1'b1; pol = 2'b00;
    applyStimulus(5'd0, 5'd4);

    #12;
    checkOutput("reset_mout", 32'(mout), 32'd0);
    checkOutput("reset_cnt", 32'(cnt), 32'd0);
    checkOutput("reset_pe", 32'(periodEnd), 32'd0);

    @(negedge clk) rstN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_cnt", 32'(cnt), 32'd0);
    checkOutput("idle_mout", 32'(mout), 32'd0);
    checkOutput("idle_pe", 32'(periodEnd), 32'd0);

    // Edge mode, duty 4 of 16
    en = 1'b1;
    syncPeriod("edge_sync");
    measure(32);
    checkOutput("edge_hi0", 32'(hi0), 32'd8);
    checkOutput("edge_first0", 32'(first0), 32'd1);
    checkOutput("edge_tog0", 32'(tog0), 32'd1);
    checkOutput("edge_hi1", 32'(hi1), 32'd0);
    checkOutput("edge_pe", 32'(peCnt), 32'd1);

    // Duty limits 0 and full scale
    applyStimulus(5'd16, 5'd0);
    syncPeriod("limit_sync");
    measure(96);
    checkOutput("limit_hi0", 32'(hi0), 32'd0);
    checkOutput("limit_hi1", 32'(hi1), 32'd96);
    checkOutput("limit_tog0", 32'(tog0), 32'd0);
    checkOutput("limit_tog1", 32'(tog1), 32'd0);
    checkOutput("limit_pe", 32'(peCnt), 32'd3);

    // Shadow update mid-period
    applyStimulus(5'd0, 5'd4);
    syncPeriod("shadow_sync");
    measure(12);
    checkOutput("shadow_cnt6", 32'(cnt), 32'd6);
    checkOutput("shadow_hi_a", 32'(hi0), 32'd8);
    applyStimulus(5'd0, 5'd12);
    measure(20);
    checkOutput("shadow_hi_b", 32'(hi0), 32'd0);
    checkOutput("shadow_pe_b", 32'(peCnt), 32'd1);
    measure(32);
    checkOutput("shadow_hi_new", 32'(hi0), 32'd24);
    loadEn = 1'b0;
    applyStimulus(5'd0, 5'd4);
    measure(32);
    checkOutput("noload_hi_a", 32'(hi0), 32'd24);
    measure(32);
    checkOutput("noload_hi_b", 32'(hi0), 32'd24);
    loadEn = 1'b1;

    // Center mode, duty 8: 30 ticks per period
    mode = 1'b1;
    applyStimulus(5'd0, 5'd8);
    syncPeriod("center_sync");
    measure(60);
    checkOutput("center_hi0", 32'(hi0), 32'd30);
    checkOutput("center_pe", 32'(peCnt), 32'd1);
    checkOutput("center_tog0", 32'(tog0), 32'd2);
    checkOutput("center_first0", 32'(first0), 32'd1);
    checkOutput("center_last0", 32'(prev0), 32'd1);
    measure(60);
    checkOutput("center_hi0_b", 32'(hi0), 32'd30);
    checkOutput("center_tog0_b", 32'(tog0), 32'd2);
    mode = 1'b0;
    syncPeriod("back_edge_sync");

    // Polarity on channel 1
    pol = 2'b10;
    applyStimulus(5'd4, 5'd8);
    syncPeriod("pol_sync");
    measure(32);
    checkOutput("pol_hi1", 32'(hi1), 32'd24);
    checkOutput("pol_hi0", 32'(hi0), 32'd16);
    checkOutput("pol_pe", 32'(peCnt), 32'd1);

    // Disable mid-period
    repeat (9) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("dis_cnt", 32'(cnt), 32'd0);
    checkOutput("dis_mout", 32'(mout), 32'd2);
    checkOutput("dis_pe", 32'(periodEnd), 32'd0);
    measure(10);
    checkOutput("dis_pe_run", 32'(peCnt), 32'd0);
    checkOutput("dis_hi1", 32'(hi1), 32'd10);

    // Re-enable restarts from zero, first boundary after a full period
    en = 1'b1;
    @(negedge clk);
    checkOutput("reen_cnt0", 32'(cnt), 32'd0);
    @(negedge clk);
    checkOutput("reen_cnt1", 32'(cnt), 32'd1);
    k = 2;
    do begin
      @(negedge clk);
      k++;
    end while (periodEnd !== 1'b1 && k < 200);
    checkOutput("reen_first_pe", 32'(k), 32'd32);

    // Asynchronous reset between edges
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("areset_mout", 32'(mout), 32'd0);
    checkOutput("areset_cnt", 32'(cnt), 32'd0);
    checkOutput("areset_pe", 32'(periodEnd), 32'd0);
    div = 32'd5;
    @(negedge clk) rstN = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("div5_cnt_before", 32'(cnt), 32'd0);
    @(negedge clk);
    checkOutput("div5_cnt_tick", 32'(cnt), 32'd1);

    // DIV=0 behaves as 1
    @(posedge clk);
    #3 rstN = 1'b0;
    div = 32'd0;
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);
    checkOutput("div0_cnt1", 32'(cnt), 32'd1);
    @(negedge clk);
    checkOutput("div0_cnt2", 32'(cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
